ssd_scan: RTL and testbench
===========================

SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 Parameter DIV, default 50000, number of clk cycles each digit is displayed; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 load_valid  input  1  producer offers a new display word.
REQ-005 load_ready  output  1  block can accept a display word.
REQ-006 load_data  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 load_dp  input  4  decimal-point enables per digit, bit i for digit i, active-high.
REQ-008 blank_lz  input  1  leading-zero blanking enable, sampled live every cycle.
REQ-009 an  output  4  digit enables, one-hot active-low, bit i selects digit i.
REQ-010 seg  output  8  segments active-low; [6:0] = g..a, [7] = dp.

Function
REQ-011 States: IDLE (nothing loaded since reset) and SCAN; the block SHALL have no other states.
REQ-012 Transfer occurs on a rising edge where load_valid && load_ready; load_data and load_dp are captured only on transfer.
REQ-013 load_ready SHALL equal !pending, where pending is a one-deep holding buffer flag; it is a combinational function of registered state only.
REQ-014 IDLE: an = 4'hF and seg = 8'hFF; the first transfer loads the word directly into the display register, leaves pending clear, and enters SCAN with digit index 0 and prescaler 0.
REQ-015 SCAN: a transfer writes the holding buffer and sets pending; the display register is not changed by the transfer.
REQ-016 Prescaler counts 0..DIV-1 and wraps; tick is asserted in the cycle it equals DIV-1.
REQ-017 On tick, digit index increments 0->1->2->3->0.
REQ-018 On tick with index 3 and pending set, the holding buffer is copied to the display register and pending clears in the same edge (tear-free update at frame boundary).
REQ-019 In the commit cycle of REQ-018, load_ready is low, so no transfer occurs; a transfer is possible from the next cycle onward.
REQ-020 an and seg are registered and reflect the digit index with exactly one cycle of latency.
REQ-021 Glyphs: seg[6:0] = standard active-low hex pattern, i.e. 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E (hex).
REQ-022 seg[7] = ~dp bit of the displayed digit.
REQ-023 With blank_lz high, digit i (i=1..3) is blanked when its nibble and every higher nibble are zero; digit 0 is never blanked.
REQ-024 A blanked digit drives seg = 8'hFF, including dp, while an still selects it.
REQ-025 In SCAN exactly one an bit is low in every cycle.

Reset
REQ-026 While rst_n is low at an edge: state = IDLE, pending = 0, display register = 0, holding buffer = 0, prescaler = 0, index = 0, an = 4'hF, seg = 8'hFF.
REQ-027 The output values of REQ-026 hold from the first edge with rst_n low onward.
REQ-028 Reset asserted mid-scan or with pending set discards all data; no partial commit occurs.
REQ-029 load_ready is 1 during and immediately after reset.

Verification (DIV=4)
REQ-030 Reset, no load, 100 cycles -> an=F, seg=FF throughout, load_ready=1.
REQ-031 Load 16'h1234, dp=0 -> next cycle an=E, seg=99 (digit "4"); the an pattern cycles E,D,B,7 every 4 cycles; seg is 99, B0, A4, F9.
REQ-032 In SCAN with 1234 displayed, load 16'hABCD at index 1 -> load_ready drops, display unchanged until the tick at index 3, then digit 0 shows 8'hA1 and load_ready returns to 1 one cycle after the commit.
REQ-033 Load 16'h0005, dp=4'b0001, blank_lz=1 -> digit 0 seg=12, digits 1-3 seg=FF; with blank_lz=0 -> digits 1-3 seg=C0.
REQ-034 load_valid held high with a pending word -> exactly one transfer per commit, none in the commit cycle, no word dropped or duplicated.
REQ-035 rst_n pulsed low for one cycle mid-frame with pending set -> an=F, seg=FF, load_ready=1, and the old word does not reappear after the next load.

Source files
------------

// File: rtl/ssd_scan_if.sv
// Load channel for ssd_scan: the producer offers a 16-bit hex word plus
// per-digit decimal points using a valid/ready handshake.
interface ssd_scan_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;

  modport master (output load_valid, output load_data, output load_dp, input load_ready);
  modport slave  (input load_valid, input load_data, input load_dp, output load_ready);
endinterface

// File: rtl/ssd_scan.sv
// Four-digit multiplexed seven-segment scanner with a one-deep holding buffer.
// New words are swapped into the display only at the frame boundary.
module ssd_scan #(
  parameter int unsigned DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  ssd_scan_if.slave  ld,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(DIV - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        pending;
  logic [15:0] disp_data, hold_data;
  logic [3:0]  disp_dp, hold_dp;
  logic [PW-1:0] presc;
  logic [1:0]  idx;
  logic        xfer, tick, commit;
  logic [3:0]  an_d, nib;
  logic [7:0]  seg_d;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // A digit is blank when it and every more significant nibble are zero.
  function automatic logic blanked(input logic [15:0] d, input logic [1:0] i, input logic en);
    case (i)
      2'd1:    blanked = en && (d[15:4] == 12'h000);
      2'd2:    blanked = en && (d[15:8] == 8'h00);
      2'd3:    blanked = en && (d[15:12] == 4'h0);
      default: blanked = 1'b0;
    endcase
  endfunction

  assign ld.load_ready = !pending;
  assign xfer   = ld.load_valid && !pending;
  assign tick   = (state == SCAN) && (presc == TOP);
  assign commit = tick && (idx == 2'd3) && pending;
  assign nib    = disp_data[{idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE && xfer) state_nxt = SCAN;
  end

  always_comb begin
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (state == SCAN) begin
      an_d = ~(4'b0001 << idx);
      if (!blanked(disp_data, idx, blank_lz)) seg_d = {~disp_dp[idx], glyph(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      disp_data <= '0;
      disp_dp   <= '0;
      hold_data <= '0;
      hold_dp   <= '0;
      presc     <= '0;
      idx       <= '0;
      an        <= 4'hF;
      seg       <= 8'hFF;
    end else begin
      if (state == IDLE) begin
        if (xfer) begin
          disp_data <= ld.load_data;
          disp_dp   <= ld.load_dp;
          presc     <= '0;
          idx       <= '0;
        end
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) idx <= idx + 2'd1;
        // commit and xfer are mutually exclusive: commit needs pending, xfer needs !pending
        if (commit) begin
          disp_data <= hold_data;
          disp_dp   <= hold_dp;
          pending   <= 1'b0;
        end
        if (xfer) begin
          hold_data <= ld.load_data;
          hold_dp   <= ld.load_dp;
          pending   <= 1'b1;
        end
      end
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan.sv
// Self-checking bench for ssd_scan with DIV=4; a cycle-count based reference
// model predicts an/seg/load_ready after every rising edge.
module tb_ssd_scan;
  localparam int DIV = 4;
  localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       blank_lz;
  logic [3:0] an;
  logic [7:0] seg;

  ssd_scan_if ifc ();

  ssd_scan #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld       (ifc),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          m_scan, m_pend, m_xfer;
  logic [15:0] m_disp, m_hold;
  logic [3:0]  m_ddp, m_hdp;
  int          m_cnt, m_nx, d_nx;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_ready;

  // Predict outputs of the coming edge from pre-edge model state, then advance the model.
  task automatic cycle();
    int i;
    logic [3:0] nib;
    i = (m_cnt / DIV) % 4;
    nib = m_disp[4*i +: 4];
    exp_an = 4'hF;
    exp_seg = 8'hFF;
    if (rst_n && m_scan) begin
      exp_an = ~(4'b0001 << i);
      if (!(blank_lz && i > 0 && (m_disp >> (4*i)) == 16'h0)) exp_seg = {~m_ddp[i], GLY[nib]};
    end
    if (ifc.load_valid && ifc.load_ready) d_nx++;
    m_xfer = 1'b0;
    if (!rst_n) begin
      m_scan = 0; m_pend = 0; m_disp = '0; m_hold = '0; m_ddp = '0; m_hdp = '0; m_cnt = 0;
    end else if (!m_scan) begin
      if (ifc.load_valid) begin
        m_xfer = 1'b1; m_scan = 1; m_disp = ifc.load_data; m_ddp = ifc.load_dp; m_cnt = 0;
      end
    end else begin
      if ((m_cnt % DIV) == DIV - 1 && i == 3 && m_pend) begin
        m_disp = m_hold; m_ddp = m_hdp; m_pend = 0;
      end else if (ifc.load_valid && !m_pend) begin
        m_hold = ifc.load_data; m_hdp = ifc.load_dp; m_pend = 1; m_xfer = 1'b1;
      end
      m_cnt++;
    end
    if (m_xfer) m_nx++;
    exp_ready = !m_pend;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int digit_of(input logic [3:0] a);
    case (a)
      4'hE: digit_of = 0;
      4'hD: digit_of = 1;
      4'hB: digit_of = 2;
      4'h7: digit_of = 3;
      default: digit_of = -1;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (an !== 4'hF || seg !== 8'hFF || ifc.load_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d an=%h seg=%h rdy=%b want F FF 1", k, an, seg, ifc.load_ready);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cycle();
      checks++;
      if (an !== 4'hF || seg !== 8'hFF || ifc.load_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_no_load cyc=%0d an=%h seg=%h rdy=%b want F FF 1", k, an, seg, ifc.load_ready);
      end
    end
  endtask

  task automatic test_load_1234();
    logic [3:0] at [4];
    logic [7:0] st [4];
    at = '{4'hE, 4'hD, 4'hB, 4'h7};
    st = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    ifc.load_valid = 1'b1; ifc.load_data = 16'h1234; ifc.load_dp = 4'h0; blank_lz = 1'b0;
    cycle();
    ifc.load_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      checks++;
      if (an !== at[k/4] || seg !== st[k/4] || an !== exp_an || seg !== exp_seg || ifc.load_ready !== exp_ready) begin
        errors++;
        $display("FAIL load_1234 k=%0d an=%h seg=%h want an=%h seg=%h rdy=%b/%b",
                 k, an, seg, at[k/4], st[k/4], ifc.load_ready, exp_ready);
      end
    end
  endtask

  task automatic test_pending_commit();
    int guard;
    guard = 0;
    while ((m_cnt / DIV) % 4 != 1 && guard < 20) begin cycle(); guard++; end
    ifc.load_valid = 1'b1; ifc.load_data = 16'hABCD; ifc.load_dp = 4'h0;
    cycle();
    ifc.load_valid = 1'b0;
    checks++;
    if (ifc.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL pending_ready ready=%b want 0", ifc.load_ready);
    end
    guard = 0;
    while (m_disp != 16'hABCD && guard < 40) begin
      cycle();
      guard++;
      checks++;
      if (an !== exp_an || seg !== exp_seg || ifc.load_ready !== exp_ready) begin
        errors++;
        $display("FAIL pending_hold g=%0d an=%h/%h seg=%h/%h rdy=%b/%b",
                 guard, an, exp_an, seg, exp_seg, ifc.load_ready, exp_ready);
      end
    end
    checks++;
    if (ifc.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL commit_ready ready=%b want 1", ifc.load_ready);
    end
    cycle();
    checks++;
    if (an !== 4'hE || seg !== 8'hA1) begin
      errors++;
      $display("FAIL commit_digit0 an=%h seg=%h want E A1", an, seg);
    end
  endtask

  task automatic test_blank();
    int guard, d;
    ifc.load_valid = 1'b1; ifc.load_data = 16'h0005; ifc.load_dp = 4'b0001; blank_lz = 1'b1;
    cycle();
    ifc.load_valid = 1'b0;
    guard = 0;
    while (m_disp != 16'h0005 && guard < 40) begin cycle(); guard++; end
    cycle();
    for (int k = 0; k < 16; k++) begin
      cycle();
      d = digit_of(an);
      checks++;
      if (d < 0 || seg !== ((d == 0) ? 8'h12 : 8'hFF) || seg !== exp_seg) begin
        errors++;
        $display("FAIL blank_on k=%0d an=%h seg=%h exp_seg=%h", k, an, seg, exp_seg);
      end
    end
    blank_lz = 1'b0;
    cycle();
    for (int k = 0; k < 16; k++) begin
      cycle();
      d = digit_of(an);
      checks++;
      if (d < 0 || seg !== ((d == 0) ? 8'h12 : 8'hC0) || seg !== exp_seg) begin
        errors++;
        $display("FAIL blank_off k=%0d an=%h seg=%h exp_seg=%h", k, an, seg, exp_seg);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [8];
    int k, dn0, mn0, guard;
    for (int j = 0; j < 8; j++) w[j] = 16'($urandom);
    dn0 = d_nx; mn0 = m_nx; k = 0; guard = 0;
    ifc.load_valid = 1'b1; ifc.load_data = w[0]; ifc.load_dp = 4'($urandom);
    while (k < 8 && guard < 300) begin
      cycle();
      guard++;
      checks++;
      if (an !== exp_an || seg !== exp_seg || ifc.load_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b g=%0d an=%h/%h seg=%h/%h rdy=%b/%b",
                 guard, an, exp_an, seg, exp_seg, ifc.load_ready, exp_ready);
      end
      if (m_xfer) begin
        k++;
        if (k < 8) begin ifc.load_data = w[k]; ifc.load_dp = 4'($urandom); end
      end
    end
    ifc.load_valid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      cycle();
      checks++;
      if (an !== exp_an || seg !== exp_seg || ifc.load_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_drain j=%0d an=%h/%h seg=%h/%h", j, an, exp_an, seg, exp_seg);
      end
    end
    checks++;
    if (d_nx - dn0 !== 8 || m_nx - mn0 !== 8) begin
      errors++;
      $display("FAIL b2b_count dut_xfers=%0d model_xfers=%0d want 8", d_nx - dn0, m_nx - mn0);
    end
  endtask

  task automatic test_reset_midframe();
    int guard;
    guard = 0;
    ifc.load_valid = 1'b1; ifc.load_data = 16'h9876; ifc.load_dp = 4'hF;
    while (!m_pend && guard < 10) begin cycle(); guard++; end
    ifc.load_valid = 1'b0;
    cycle(); cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    checks++;
    if (an !== 4'hF || seg !== 8'hFF || ifc.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset an=%h seg=%h rdy=%b want F FF 1", an, seg, ifc.load_ready);
    end
    ifc.load_valid = 1'b1; ifc.load_data = 16'h00C0; ifc.load_dp = 4'h0; blank_lz = 1'b0;
    cycle();
    ifc.load_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      checks++;
      if (an !== exp_an || seg !== exp_seg || ifc.load_ready !== exp_ready) begin
        errors++;
        $display("FAIL after_reset k=%0d an=%h/%h seg=%h/%h rdy=%b/%b",
                 k, an, exp_an, seg, exp_seg, ifc.load_ready, exp_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      ifc.load_valid = ($urandom_range(0, 99) < 30);
      ifc.load_data  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      ifc.load_dp    = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      rst_n = ($urandom_range(0, 199) != 0);
      cycle();
      checks++;
      if (an !== exp_an || seg !== exp_seg || ifc.load_ready !== exp_ready) begin
        errors++;
        $display("FAIL random k=%0d an=%h/%h seg=%h/%h rdy=%b/%b",
                 k, an, exp_an, seg, exp_seg, ifc.load_ready, exp_ready);
      end
    end
    rst_n = 1'b1;
    ifc.load_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; blank_lz = 1'b0;
    ifc.load_valid = 1'b0; ifc.load_data = '0; ifc.load_dp = '0;
    m_scan = 0; m_pend = 0; m_disp = '0; m_hold = '0; m_ddp = '0; m_hdp = '0;
    m_cnt = 0; m_nx = 0; d_nx = 0;
    @(negedge clk);
    test_reset();
    test_load_1234();
    test_pending_commit();
    test_blank();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
